// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_pkg
// Description : Shared types and constants for the external SRAM arbiter:
//               sequencer state encoding and the captured request record.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_pkg;

    localparam int c_ADDR_W = 20;
    localparam int c_DATA_W = 16;

    // One SRAM_CLK cycle per state; a full access is ACC1 -> ACC2 -> DONE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC1 = 2'd1,
        ACC2 = 2'd2,
        DONE = 2'd3
    } state_t;

    // Request captured at grant time so the SRAM pins stay stable for the
    // whole access regardless of what the requester does meanwhile.
    typedef struct packed {
        logic [c_ADDR_W-1:0] addr;
        logic [c_DATA_W-1:0] data;
        logic                is_write;
    } req_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker. Searches the unmasked
//               requests starting at i_rr_ptr, wrapping modulo N, and
//               returns a one-hot grant plus a valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_rr_ptr,
    input  logic [N-1:0]     i_mask,
    output logic [N-1:0]     o_grant,
    output logic             o_valid
);

    logic [N-1:0] w_eligible;
    int           w_idx;
    logic         w_found;

    assign w_eligible = i_req & ~i_mask;

    // First eligible requester at or after the pointer wins.
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int i = 0; i < N; i++) begin
            w_idx = (int'(i_rr_ptr) + i) % N;
            if (!w_found && w_eligible[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

    assign o_valid = w_found;

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter
// Description : Round-robin arbiter and 3-cycle access sequencer for a single
//               external 16-bit asynchronous SRAM shared by NUM_PORTS
//               requesters. Read data returns on a shared bus qualified by a
//               per-port Done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = c_ADDR_W,
    parameter int DATA_W    = c_DATA_W
) (
    input  logic                        SRAM_CLK,
    input  logic                        Reset,
    input  logic [NUM_PORTS-1:0]        QueueReadReq,
    input  logic [NUM_PORTS-1:0]        QueueWriteReq,
    input  logic [NUM_PORTS*ADDR_W-1:0] AddressToSRAM,
    input  logic [NUM_PORTS*DATA_W-1:0] DataToSRAM,
    output logic [DATA_W-1:0]           DataFromSRAM,
    output logic [NUM_PORTS-1:0]        Done,
    output logic [NUM_PORTS-1:0]        Grant,
    output logic [ADDR_W-1:0]           SRAM_ADDR,
    inout  wire  [DATA_W-1:0]           SRAM_DQ,
    output logic                        SRAM_CE_N,
    output logic                        SRAM_OE_N,
    output logic                        SRAM_WE_N,
    output logic                        SRAM_UB_N,
    output logic                        SRAM_LB_N
);

    localparam int c_PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [c_PTR_W-1:0]     r_rr_ptr;
    logic [NUM_PORTS-1:0]   r_grant;
    req_t                   r_req;
    logic [DATA_W-1:0]      r_rdata;

    logic [NUM_PORTS-1:0]   w_any_req;
    logic [NUM_PORTS-1:0]   w_mask;
    logic [NUM_PORTS-1:0]   w_arb_grant;
    logic                   w_arb_valid;
    logic                   w_arb_slot;
    logic                   w_take;
    logic [c_PTR_W-1:0]     w_gidx;
    logic                   w_dq_oe;

    // Direction doesn't matter for arbitration; write-wins is resolved at capture.
    assign w_any_req  = QueueReadReq | QueueWriteReq;
    // The port just served is still holding its request during DONE.
    assign w_mask     = (r_state == DONE) ? r_grant : '0;
    assign w_arb_slot = (r_state == IDLE) || (r_state == DONE);
    assign w_take     = w_arb_slot && w_arb_valid;

    rr_arbiter #(
        .N     (NUM_PORTS),
        .PTR_W (c_PTR_W)
    ) u_rr_arbiter (
        .i_req    (w_any_req),
        .i_rr_ptr (r_rr_ptr),
        .i_mask   (w_mask),
        .o_grant  (w_arb_grant),
        .o_valid  (w_arb_valid)
    );

    // Convert the one-hot arbiter result into a port index.
    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_arb_grant[i]) begin
                w_gidx = c_PTR_W'(i);
            end
        end
    end

    // State register; reset aborts any access in flight.
    always_ff @(posedge SRAM_CLK) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: fixed ACC1 -> ACC2 -> DONE, re-arbitrating in IDLE and DONE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    w_next_state = w_take ? ACC1 : IDLE;
            ACC1:    w_next_state = ACC2;
            ACC2:    w_next_state = DONE;
            DONE:    w_next_state = w_take ? ACC1 : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Grant, pointer and request capture at the arbitration point.
    always_ff @(posedge SRAM_CLK) begin
        if (Reset) begin
            r_grant  <= '0;
            r_rr_ptr <= '0;
            r_req    <= '0;
        end else if (w_take) begin
            r_grant        <= w_arb_grant;
            r_rr_ptr       <= (w_gidx == c_PTR_W'(NUM_PORTS - 1)) ? '0 : w_gidx + 1'b1;
            r_req.addr     <= AddressToSRAM[w_gidx*ADDR_W +: ADDR_W];
            r_req.data     <= DataToSRAM[w_gidx*DATA_W +: DATA_W];
            r_req.is_write <= QueueWriteReq[w_gidx];
        end else if (r_state == DONE) begin
            r_grant <= '0;
        end
    end

    // Read data is sampled at the end of ACC2 and held until the next read.
    always_ff @(posedge SRAM_CLK) begin
        if (Reset) begin
            r_rdata <= '0;
        end else if (r_state == ACC2 && !r_req.is_write) begin
            r_rdata <= SRAM_DQ;
        end
    end

    // SRAM pin decode; DQ is only driven by us while OE_N is high.
    always_comb begin
        SRAM_CE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        SRAM_WE_N = 1'b1;
        SRAM_UB_N = 1'b1;
        SRAM_LB_N = 1'b1;
        w_dq_oe   = 1'b0;
        Done      = '0;
        case (r_state)
            ACC1: begin
                SRAM_CE_N = 1'b0;
                SRAM_UB_N = 1'b0;
                SRAM_LB_N = 1'b0;
                if (r_req.is_write) begin
                    SRAM_WE_N = 1'b0;
                    w_dq_oe   = 1'b1;
                end else begin
                    SRAM_OE_N = 1'b0;
                end
            end
            ACC2: begin
                // WE_N rising into this cycle commits the write; data held.
                SRAM_CE_N = 1'b0;
                SRAM_UB_N = 1'b0;
                SRAM_LB_N = 1'b0;
                if (r_req.is_write) begin
                    w_dq_oe = 1'b1;
                end else begin
                    SRAM_OE_N = 1'b0;
                end
            end
            DONE: begin
                Done = r_grant;
            end
            default: begin
                Done = '0;
            end
        endcase
    end

    assign Grant        = r_grant;
    assign SRAM_ADDR    = r_req.addr;
    assign DataFromSRAM = r_rdata;
    assign SRAM_DQ      = w_dq_oe ? r_req.data : {DATA_W{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_arbiter
// Description : Scoreboard bench for sram_arbiter with a behavioural SRAM.
//               Stimulus pushes the expected completion (port, cycle, data);
//               a monitor pops and compares on every Done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

    localparam int c_NP = 4;
    localparam int c_AW = 20;
    localparam int c_DW = 16;

    logic                 SRAM_CLK = 1'b0;
    logic                 Reset    = 1'b1;
    logic [c_NP-1:0]      rd_req   = '0;
    logic [c_NP-1:0]      wr_req   = '0;
    logic [c_NP-1:0]      hold     = '0;
    logic [c_NP*c_AW-1:0] addr_bus = '0;
    logic [c_NP*c_DW-1:0] data_bus = '0;

    logic [c_DW-1:0] DataFromSRAM;
    logic [c_NP-1:0] Done;
    logic [c_NP-1:0] Grant;
    logic [c_AW-1:0] SRAM_ADDR;
    wire  [c_DW-1:0] SRAM_DQ;
    logic SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;

    always #5 SRAM_CLK = ~SRAM_CLK;

    sram_arbiter #(
        .NUM_PORTS (c_NP),
        .ADDR_W    (c_AW),
        .DATA_W    (c_DW)
    ) dut (
        .SRAM_CLK      (SRAM_CLK),
        .Reset         (Reset),
        .QueueReadReq  (rd_req),
        .QueueWriteReq (wr_req),
        .AddressToSRAM (addr_bus),
        .DataToSRAM    (data_bus),
        .DataFromSRAM  (DataFromSRAM),
        .Done          (Done),
        .Grant         (Grant),
        .SRAM_ADDR     (SRAM_ADDR),
        .SRAM_DQ       (SRAM_DQ),
        .SRAM_CE_N     (SRAM_CE_N),
        .SRAM_OE_N     (SRAM_OE_N),
        .SRAM_WE_N     (SRAM_WE_N),
        .SRAM_UB_N     (SRAM_UB_N),
        .SRAM_LB_N     (SRAM_LB_N)
    );

    // ---------------- behavioural SRAM ----------------
    // Unwritten locations read back as addr[15:0] ^ 16'h5A5A.
    logic [c_DW-1:0] mem [logic [c_AW-1:0]];
    logic            tb_drive;
    logic [c_DW-1:0] tb_rd;

    assign SRAM_DQ = tb_drive ? tb_rd : {c_DW{1'bz}};

    always @(SRAM_ADDR or SRAM_CE_N or SRAM_OE_N or SRAM_WE_N or SRAM_CLK) begin
        tb_drive = !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;
        tb_rd    = mem.exists(SRAM_ADDR) ? mem[SRAM_ADDR] : (SRAM_ADDR[15:0] ^ 16'h5A5A);
    end

    // Mid-cycle sample of an active write (WE_N low only in ACC1).
    always @(negedge SRAM_CLK) begin
        if (!SRAM_CE_N && !SRAM_WE_N) mem[SRAM_ADDR] = SRAM_DQ;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int              port;
        bit              is_read;
        logic [c_DW-1:0] data;
        int              cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc        = 0;
    int   n_tests    = 0;
    int   n_fail     = 0;
    int   viol       = 0;
    int   we_low_cnt = 0;
    int   we_low_cyc = -1;

    always @(posedge SRAM_CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: bus safety every cycle, scoreboard compare on each Done.
    always @(negedge SRAM_CLK) begin : monitor
        exp_t e;
        if (!SRAM_OE_N && !SRAM_WE_N) viol++;
        if ($countones(Grant) > 1) viol++;
        if (!SRAM_WE_N) begin
            we_low_cnt++;
            we_low_cyc = cyc;
        end
        if (Done != '0) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(Done), 32'd0);
            end else begin
                e = sb.pop_front();
                check("done_port", 32'(Done), 32'(1 << e.port));
                check("grant_at_done", 32'(Grant), 32'(1 << e.port));
                check("done_cycle", cyc, e.cyc);
                if (e.is_read) check("read_data", 32'(DataFromSRAM), 32'(e.data));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Advance one cycle; requesters drop their request once they see Done.
    task automatic step();
        @(negedge SRAM_CLK);
        for (int p = 0; p < c_NP; p++) begin
            if (Done[p] && !hold[p]) begin
                rd_req[p] = 1'b0;
                wr_req[p] = 1'b0;
            end
        end
    endtask

    task automatic issue(input int p, input bit wr, input bit rd, input logic [c_AW-1:0] a,
                         input logic [c_DW-1:0] d, input logic [c_DW-1:0] exp_d, input int off);
        exp_t e;
        addr_bus[p*c_AW +: c_AW] = a;
        data_bus[p*c_DW +: c_DW] = d;
        wr_req[p] = wr;
        rd_req[p] = rd;
        e.port    = p;
        e.is_read = !wr;
        e.data    = exp_d;
        e.cyc     = cyc + off;
        sb.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) step();
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        step();
    endtask

    // ---------------- scenarios ----------------
    initial begin : stim
        int c0;
        int w0;

        // Reset state
        step();
        step();
        check("rst_grant", 32'(Grant), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_rdata", 32'(DataFromSRAM), 32'd0);
        check("rst_addr", 32'(SRAM_ADDR), 32'd0);
        check("rst_ctrl_n", 32'({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}), 32'h1F);
        Reset = 1'b0;

        // Single write then read on port 0
        c0 = cyc;
        w0 = we_low_cnt;
        issue(0, 1'b1, 1'b0, 20'h00F0F, 16'hF0F0, 16'h0000, 3);
        drain();
        check("wr_we_low_cycles", we_low_cnt - w0, 1);
        check("wr_we_low_at_acc1", we_low_cyc, c0 + 1);
        issue(0, 1'b0, 1'b1, 20'h00F0F, 16'h0000, 16'hF0F0, 3);
        drain();

        // All four ports read at once after reset: order 0,1,2,3
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        issue(0, 1'b0, 1'b1, 20'h00100, 16'h0000, 16'h5B5A, 3);
        issue(1, 1'b0, 1'b1, 20'h00101, 16'h0000, 16'h5B5B, 6);
        issue(2, 1'b0, 1'b1, 20'h00102, 16'h0000, 16'h5B58, 9);
        issue(3, 1'b0, 1'b1, 20'h00103, 16'h0000, 16'h5B59, 12);
        drain();

        // Fairness: ports 1 and 3 request continuously
        hold = 4'b1010;
        issue(1, 1'b0, 1'b1, 20'h00200, 16'h0000, 16'h585A, 3);
        issue(3, 1'b0, 1'b1, 20'h00300, 16'h0000, 16'h595A, 6);
        issue(1, 1'b0, 1'b1, 20'h00200, 16'h0000, 16'h585A, 9);
        issue(3, 1'b0, 1'b1, 20'h00300, 16'h0000, 16'h595A, 12);
        for (int i = 0; i < 12; i++) step();
        hold   = '0;
        rd_req = '0;
        drain();

        // Read+write on port 2: the write wins
        issue(2, 1'b1, 1'b1, 20'hFFFFF, 16'h0FF0, 16'h0000, 3);
        drain();
        issue(2, 1'b0, 1'b1, 20'hFFFFF, 16'h0000, 16'h0FF0, 3);
        drain();

        // Reset during ACC1 of a write: aborted, no Done
        addr_bus[0 +: c_AW] = 20'h00AAA;
        data_bus[0 +: c_DW] = 16'h5555;
        wr_req[0] = 1'b1;
        step();
        check("abort_in_acc1_we_n", 32'(SRAM_WE_N), 32'd0);
        Reset  = 1'b1;
        wr_req = '0;
        step();
        check("abort_ctrl_n", 32'({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}), 32'h1F);
        check("abort_done", 32'(Done), 32'd0);
        check("abort_grant", 32'(Grant), 32'd0);
        Reset = 1'b0;
        // Pointer restarts at 0 so port 0 beats port 3
        issue(3, 1'b0, 1'b1, 20'h00403, 16'h0000, 16'h5E59, 6);
        issue(0, 1'b0, 1'b1, 20'h00400, 16'h0000, 16'h5E5A, 3);
        // issue order in the queue must follow completion order
        begin
            exp_t a;
            exp_t b;
            b = sb.pop_back();
            a = sb.pop_back();
            sb.push_back(b);
            sb.push_back(a);
        end
        drain();

        check("bus_safety_violations", viol, 0);
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
